// File: rtl/food_ctrl.sv
// Food cell tracker: detects the snake head landing on the food, pulses add_cube, relocates the food.
// Latency: add_cube one cycle after the hit strobe; new food earliest 2 cycles, at most 2+MAX_TRIES.
// No backpressure: head_valid is a fire-and-forget strobe, ignored while a relocation is in progress.
`timescale 1ns/1ps
module food_ctrl #(
   parameter int          GRID_W    = 40,
   parameter int          GRID_H    = 30,
   parameter int          COORD_W   = 6,
   parameter int          INIT_X    = 20,
   parameter int          INIT_Y    = 15,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_TRIES = 15
) (
   input  logic               CLK_50M,
   input  logic               RST,
   input  logic               game_en,
   input  logic               head_valid,
   input  logic [COORD_W-1:0] head_x,
   input  logic [COORD_W-1:0] head_y,
   output logic [COORD_W-1:0] food_x,
   output logic [COORD_W-1:0] food_y,
   output logic               food_valid,
   output logic               add_cube
);

   typedef enum logic {ARMED = 1'b0, PLACE = 1'b1} state_t;

   localparam logic [COORD_W-1:0] GW      = COORD_W'(GRID_W);
   localparam logic [COORD_W-1:0] GH      = COORD_W'(GRID_H);
   localparam logic [COORD_W:0]   GW_W    = (COORD_W+1)'(GRID_W);
   localparam logic [COORD_W:0]   HALF_W  = (COORD_W+1)'(GRID_W / 2);
   localparam logic [7:0]         TRY_LIM = 8'(MAX_TRIES);

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [7:0]         try_cnt_q, try_cnt_d;
   logic [COORD_W-1:0] food_x_q, food_x_d;
   logic [COORD_W-1:0] food_y_q, food_y_d;
   logic               food_valid_q, food_valid_d;
   logic               add_cube_q, add_cube_d;

   logic               lfsr_fb;
   logic [COORD_W-1:0] cx, cy;
   logic               hit, accept;
   logic [COORD_W:0]   fb_sum, fb_mod;
   logic [COORD_W-1:0] fb_x, fb_y;

   // Candidate cell, hit detection and the deterministic fallback cell
   always_comb begin
      lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
      cx      = lfsr_q[COORD_W-1:0];
      cy      = lfsr_q[2*COORD_W-1:COORD_W];
      hit     = game_en && head_valid && (head_x == food_x_q) && (head_y == food_y_q);
      accept  = (cx < GW) && (cy < GH) && !((cx == head_x) && (cy == head_y));
      // Half a playfield away horizontally; out-of-range rows collapse to row 0
      fb_sum  = {1'b0, head_x} + HALF_W;
      fb_mod  = fb_sum % GW_W;
      fb_x    = fb_mod[COORD_W-1:0];
      fb_y    = (head_y < GH) ? head_y : '0;
   end

   // Next-state logic: LFSR free-runs, FSM arms on hit and relocates in PLACE
   always_comb begin
      state_d      = state_q;
      lfsr_d       = {lfsr_fb, lfsr_q[15:1]};
      try_cnt_d    = try_cnt_q;
      food_x_d     = food_x_q;
      food_y_d     = food_y_q;
      food_valid_d = food_valid_q;
      add_cube_d   = 1'b0;
      case (state_q)
         ARMED: begin
            if (hit) begin
               add_cube_d   = 1'b1;
               food_valid_d = 1'b0;
               try_cnt_d    = '0;
               state_d      = PLACE;
            end
         end
         PLACE: begin
            if (accept) begin
               food_x_d     = cx;
               food_y_d     = cy;
               food_valid_d = 1'b1;
               state_d      = ARMED;
            end else if (try_cnt_q != TRY_LIM) begin
               try_cnt_d = try_cnt_q + 8'd1;
            end else begin
               food_x_d     = fb_x;
               food_y_d     = fb_y;
               food_valid_d = 1'b1;
               state_d      = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         state_q      <= ARMED;
         lfsr_q       <= LFSR_SEED;
         try_cnt_q    <= '0;
         food_x_q     <= COORD_W'(INIT_X);
         food_y_q     <= COORD_W'(INIT_Y);
         food_valid_q <= 1'b1;
         add_cube_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         try_cnt_q    <= try_cnt_d;
         food_x_q     <= food_x_d;
         food_y_q     <= food_y_d;
         food_valid_q <= food_valid_d;
         add_cube_q   <= add_cube_d;
      end
   end

   assign food_x     = food_x_q;
   assign food_y     = food_y_q;
   assign food_valid = food_valid_q;
   assign add_cube   = add_cube_q;

endmodule

// File: tb/tb_food_ctrl.sv
// Directed bench for food_ctrl: reset, hit/miss, strobes during relocation, fallback, reset mid-relocation.
// A second instance with MAX_TRIES=0 and an out-of-range seed exercises the fallback path.
// All checks sample 1 ns after the rising edge; inputs are driven at the same point.
`timescale 1ns/1ps
module tb_food_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       ge, hv, ge2, hv2;
   logic [5:0] hx, hy, hx2, hy2;
   logic [5:0] fx, fy, fx2, fy2;
   logic       fv, ac, fv2, ac2;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   food_ctrl u_dut (
      .CLK_50M(clk), .RST(rst), .game_en(ge), .head_valid(hv),
      .head_x(hx), .head_y(hy), .food_x(fx), .food_y(fy),
      .food_valid(fv), .add_cube(ac)
   );

   food_ctrl #(.INIT_X(30), .INIT_Y(5), .LFSR_SEED(16'h007E), .MAX_TRIES(0)) u_fb (
      .CLK_50M(clk), .RST(rst), .game_en(ge2), .head_valid(hv2),
      .head_x(hx2), .head_y(hy2), .food_x(fx2), .food_y(fy2),
      .food_valid(fv2), .add_cube(ac2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ox, oy, ax, ay;
      int pulses, consec, bad, got;
      logic prev_ac, changed;

      rst = 1'b1; ge = 1'b0; hv = 1'b0; hx = '0; hy = '0;
      ge2 = 1'b0; hv2 = 1'b0; hx2 = '0; hy2 = '0;

      // 1. reset values
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_food_x", 32'(fx), 32'd20);
      chk("rst_food_y", 32'(fy), 32'd15);
      chk("rst_food_valid", 32'(fv), 32'd1);
      chk("rst_add_cube", 32'(ac), 32'd0);
      chk("rst_lfsr", 32'(u_dut.lfsr_q), 32'hACE1);

      // 5. fallback: seed 0x007E shifts to 0x803F, cx=63 rejected, MAX_TRIES=0
      ge2 = 1'b1; hv2 = 1'b1; hx2 = 6'd30; hy2 = 6'd5;
      tick();
      hv2 = 1'b0; hy2 = 6'd40;   // live head row out of range during PLACE
      chk("fb_add_cube", 32'(ac2), 32'd1);
      chk("fb_valid_low", 32'(fv2), 32'd0);
      tick();
      chk("fb_valid", 32'(fv2), 32'd1);
      chk("fb_food_x", 32'(fx2), 32'd10);   // (30+20)%40
      chk("fb_food_y", 32'(fy2), 32'd0);
      chk("fb_add_low", 32'(ac2), 32'd0);
      ge2 = 1'b0;

      // 2. basic hit at (20,15)
      ge = 1'b1; hv = 1'b1; hx = 6'd20; hy = 6'd15;
      tick();
      hv = 1'b0;
      chk("hit_add_cube", 32'(ac), 32'd1);
      chk("hit_valid_low", 32'(fv), 32'd0);
      tick();
      chk("hit_add_once", 32'(ac), 32'd0);
      for (int i = 0; i < 15 && !fv; i++) tick();
      chk("hit_valid_return", 32'(fv), 32'd1);
      chk("hit_x_inb", 32'(fx < 6'd40), 32'd1);
      chk("hit_y_inb", 32'(fy < 6'd30), 32'd1);
      chk("hit_not_head", 32'((fx == 6'd20) && (fy == 6'd15)), 32'd0);

      // 3. miss, then matching strobe with game_en low
      ox = fx; oy = fy;
      hx = ox ^ 6'd1; hy = oy; hv = 1'b1; ge = 1'b1;
      pulses = 0; changed = 1'b0;
      tick();
      if (ac) pulses++;
      hx = ox; ge = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ac) pulses++;
         if (fx != ox || fy != oy || !fv) changed = 1'b1;
      end
      hv = 1'b0; ge = 1'b1;
      chk("miss_no_pulse", 32'(pulses), 32'd0);
      chk("miss_food_held", 32'(changed), 32'd0);

      // 4. strobe the old food cell every cycle through PLACE
      ox = fx; oy = fy;
      hx = ox; hy = oy; hv = 1'b1;
      pulses = 0; consec = 0; prev_ac = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ac) pulses++;
         if (ac && prev_ac) consec++;
         prev_ac = ac;
      end
      chk("place_one_pulse", 32'(pulses), 32'd1);
      chk("place_no_consec", 32'(consec), 32'd0);
      chk("place_valid", 32'(fv), 32'd1);
      chk("place_moved", 32'((fx == ox) && (fy == oy)), 32'd0);
      hx = fx; hy = fy;
      tick();
      hv = 1'b0;
      chk("second_pulse", 32'(ac), 32'd1);
      for (int i = 0; i < 20 && !fv; i++) tick();
      chk("second_valid", 32'(fv), 32'd1);

      // 6. reset in the first PLACE cycle
      hx = fx; hy = fy; hv = 1'b1;
      tick();
      hv = 1'b0;
      chk("pre_rst_pulse", 32'(ac), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_food_x", 32'(fx), 32'd20);
      chk("midrst_food_y", 32'(fy), 32'd15);
      chk("midrst_valid", 32'(fv), 32'd1);
      chk("midrst_add", 32'(ac), 32'd0);

      // 6b. 50 hits with random heads during relocation
      pulses = 0; bad = 0;
      for (int k = 0; k < 50; k++) begin
         hx = fx; hy = fy; hv = 1'b1;
         tick();
         hv = 1'b0;
         if (ac) pulses++;
         got = 0;
         for (int c = 0; c < 20 && got == 0; c++) begin
            ax = 6'($urandom_range(0, 63));
            ay = 6'($urandom_range(0, 63));
            hx = ax; hy = ay;
            tick();
            if (ac) pulses++;
            if (fv) begin
               got = 1;
               if (fx >= 6'd40 || fy >= 6'd30) bad++;
               if (fx == ax && fy == ay) bad++;
            end
         end
         if (got == 0) bad++;
      end
      chk("rand_pulses", 32'(pulses), 32'd50);
      chk("rand_placement", 32'(bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
